// File: rtl/fir_decimator_if.sv
// fir_decimator_if: stream bundle for the FIR decimator.
//   in_valid/in_data  : sample stream from the filter
//   out_ready         : consumer accepts out_data this cycle
//   clr_ovf           : clears the sticky overflow flag
//   out_valid/out_data: FIFO head presented to the consumer
//   overflow          : sticky drop indicator
//   level             : FIFO occupancy, 0..FIFO_DEPTH
// master drives the inputs (filter + consumer side), slave is the decimator.
interface fir_decimator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_ready;
    logic                  clr_ovf;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  overflow;
    logic [LW-1:0]         level;

    modport master (
        output in_valid, in_data, out_ready, clr_ovf,
        input  out_valid, out_data, overflow, level
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_ovf,
        output out_valid, out_data, overflow, level
    );
endinterface

// File: rtl/fir_decimator.sv
// fir_decimator: keeps one valid sample in every DECIM and buffers kept
// samples in a first-word-fall-through FIFO with a valid/ready output.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fir_decimator_if.slave (sample in, buffered sample out,
//           clr_ovf, sticky overflow, occupancy level)
module fir_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_decimator_if.slave      bus
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [PW-1:0]         r_phase;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_out_valid;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic                  w_keep;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic [LW-1:0]         w_level_nxt;

    always_comb begin
        w_keep = bus.in_valid && (r_phase == '0);
        w_pop  = r_out_valid && bus.out_ready;
        w_full = (r_level == LW'(FIFO_DEPTH));
        // A pop frees the head slot in the same cycle, so a full FIFO can
        // still accept a kept sample when the consumer is draining.
        w_push = w_keep && (!w_full || w_pop);
        w_drop = w_keep && w_full && !w_pop;

        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level     <= w_level_nxt;
            r_out_valid <= (w_level_nxt != '0);
            // Set has priority over clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset: out_data is masked while nothing is buffered.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.overflow  = r_ovf;
    assign bus.level     = r_level;
endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;
    logic        clk;
    logic        rst_n;
    logic        s_in_valid;
    logic [15:0] s_in_data;
    logic        s_out_ready;
    logic        s_clr_ovf;

    logic        o_vld [2];
    logic [15:0] o_dat [2];
    logic        o_ovf [2];
    logic [2:0]  o_lvl [2];

    logic [15:0] got4 [$];
    logic [15:0] got1 [$];

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Instance 0: DECIM=4, instance 1: DECIM=1; both FIFO_DEPTH=4, shared stimulus.
    for (genvar G = 0; G < 2; G++) begin : g_inst
        localparam int DEC = (G == 0) ? 4 : 1;

        fir_decimator_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) bus ();

        assign bus.in_valid  = s_in_valid;
        assign bus.in_data   = s_in_data;
        assign bus.out_ready = s_out_ready;
        assign bus.clr_ovf   = s_clr_ovf;
        assign o_vld[G] = bus.out_valid;
        assign o_dat[G] = bus.out_data;
        assign o_ovf[G] = bus.overflow;
        assign o_lvl[G] = bus.level;

        fir_decimator #(.DATA_WIDTH(16), .DECIM(DEC), .FIFO_DEPTH(4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Model: count valid samples since reset; keep index k when k % DECIM == 0.
        logic [15:0] mq [$];
        int unsigned nval;
        bit          movf;
        bit          model_ok = 0;

        always @(posedge clk) begin : model
            bit pop;
            bit keep;
            if (!rst_n) begin
                mq.delete();
                nval     = 0;
                movf     = 0;
                model_ok = 1;
            end else begin
                pop  = (mq.size() != 0) && s_out_ready;
                keep = s_in_valid && ((nval % DEC) == 0);
                if (s_in_valid) nval++;
                if (s_clr_ovf) movf = 0;
                if (pop) void'(mq.pop_front());
                if (keep) begin
                    if (mq.size() < 4) mq.push_back(s_in_data);
                    else movf = 1;
                end
            end
        end

        always @(posedge clk) begin : logger
            if (rst_n && o_vld[G] && s_out_ready) begin
                if (G == 0) got4.push_back(o_dat[G]);
                else        got1.push_back(o_dat[G]);
            end
        end

        always @(negedge clk) begin : compare
            if (model_ok) begin
                check($sformatf("out_valid[d%0d]", DEC), {31'd0, o_vld[G]}, {31'd0, mq.size() != 0});
                check($sformatf("level[d%0d]", DEC), {29'd0, o_lvl[G]}, mq.size());
                check($sformatf("out_data[d%0d]", DEC), {16'd0, o_dat[G]},
                      (mq.size() != 0) ? {16'd0, mq[0]} : 32'd0);
                check($sformatf("overflow[d%0d]", DEC), {31'd0, o_ovf[G]}, {31'd0, movf});
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
        s_in_valid  = v;
        s_in_data   = d;
        s_out_ready = rdy;
        s_clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int unsigned maxl;
        int exp4 [4] = '{1, 5, 9, 13};
        int expb [4] = '{10, 20, 30, 40};
        int expf [5] = '{1, 2, 3, 4, 99};

        s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_clr_ovf = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        step(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            check("idle_valid", {31'd0, o_vld[i]}, 0);
            check("idle_level", {29'd0, o_lvl[i]}, 0);
            check("idle_ovf",   {31'd0, o_ovf[i]}, 0);
            check("idle_data",  {16'd0, o_dat[i]}, 0);
        end

        // Decimation, continuous input
        got4.delete(); got1.delete(); maxl = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1, 16'(k), 1, 0);
            if (o_lvl[0] > maxl) maxl = o_lvl[0];
        end
        repeat (2) step(0, 0, 1, 0);
        check("dec_count", got4.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got4.size()) check("dec_seq", {16'd0, got4[i]}, exp4[i]);
        check("dec_maxlvl", maxl, 1);
        check("d1_count", got1.size(), 16);

        // Gapped input
        got4.delete(); got1.delete();
        for (int k = 1; k <= 16; k++) begin
            step(1, 16'(k), 1, 0);
            step(0, 0, 1, 0);
        end
        repeat (2) step(0, 0, 1, 0);
        check("gap_count", got4.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got4.size()) check("gap_seq", {16'd0, got4[i]}, exp4[i]);

        // Backpressure and overflow on DECIM=1
        got1.delete();
        for (int k = 1; k <= 5; k++) step(1, 16'(10 * k), 0, 0);
        check("bp_level", {29'd0, o_lvl[1]}, 4);
        check("bp_ovf",   {31'd0, o_ovf[1]}, 1);
        check("bp_head",  {16'd0, o_dat[1]}, 10);
        repeat (6) step(0, 0, 1, 0);
        check("bp_count", got1.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got1.size()) check("bp_seq", {16'd0, got1[i]}, expb[i]);
        check("bp_ovf_held", {31'd0, o_ovf[1]}, 1);
        step(0, 0, 1, 1);
        check("bp_ovf_clr", {31'd0, o_ovf[1]}, 0);

        // Full with simultaneous pop
        got1.delete();
        for (int k = 1; k <= 4; k++) step(1, 16'(k), 0, 0);
        check("full_level", {29'd0, o_lvl[1]}, 4);
        step(1, 99, 1, 0);
        check("fp_level", {29'd0, o_lvl[1]}, 4);
        check("fp_ovf",   {31'd0, o_ovf[1]}, 0);
        check("fp_head",  {16'd0, o_dat[1]}, 2);
        repeat (5) step(0, 0, 1, 0);
        check("fp_count", got1.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got1.size()) check("fp_seq", {16'd0, got1[i]}, expf[i]);

        // Reset mid-operation
        for (int k = 7; k <= 9; k++) step(1, 16'(k), 0, 0);
        check("mid_level", {29'd0, o_lvl[1]}, 3);
        rst_n = 0;
        step(1, 55, 0, 0);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            check("rst_level", {29'd0, o_lvl[i]}, 0);
            check("rst_valid", {31'd0, o_vld[i]}, 0);
            check("rst_ovf",   {31'd0, o_ovf[i]}, 0);
        end
        step(1, 123, 0, 0);
        check("post_rst_lvl4",  {29'd0, o_lvl[0]}, 1);
        check("post_rst_data4", {16'd0, o_dat[0]}, 123);
        check("post_rst_lvl1",  {29'd0, o_lvl[1]}, 1);
        repeat (3) step(0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
